// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals around mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, busy, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store access.
// Optional access watchdog enabled by defining MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D} state_t;

    localparam int STREAK_CLAMP = (MAX_D_STREAK < 1)  ? 1  :
                                  (MAX_D_STREAK > 15) ? 15 : MAX_D_STREAK;
    localparam logic [3:0] STREAK_LIMIT = 4'(STREAK_CLAMP);

    state_t        state_reg;
    logic [3:0]    streak_reg;
    logic          mem_req_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic          if_rvalid_reg;
    logic [DW-1:0] if_rdata_reg;
    logic          d_rvalid_reg;
    logic [DW-1:0] d_rdata_reg;
    logic          pick_if;
    logic          pick_d;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;
    assign bus.err = err_reg;
`else
    // Without the watchdog the timeout limit has no role.
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
    assign bus.err = 1'b0;
`endif

    // Grants are decided combinationally in IDLE; D wins ties until IF has waited too long.
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (rst_n && state_reg == IDLE) begin
            if (bus.if_req && bus.d_req) begin
                if (streak_reg == STREAK_LIMIT) pick_if = 1'b1;
                else                            pick_d  = 1'b1;
            end else begin
                pick_if = bus.if_req;
                pick_d  = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            streak_reg    <= 4'd0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rvalid_reg <= 1'b0;
            if_rdata_reg  <= '0;
            d_rvalid_reg  <= 1'b0;
            d_rdata_reg   <= '0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            to_cnt_reg    <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            err_reg       <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (pick_if) begin
                        state_reg     <= ACC_IF;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= bus.if_addr;
                        mem_wdata_reg <= '0;
                        streak_reg    <= 4'd0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                        to_cnt_reg    <= '0;
`endif
                    end else if (pick_d) begin
                        state_reg     <= ACC_D;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= bus.d_we;
                        mem_addr_reg  <= bus.d_addr;
                        mem_wdata_reg <= bus.d_wdata;
                        // Only a D win over a waiting fetch counts toward starvation.
                        if (!bus.if_req)                      streak_reg <= 4'd0;
                        else if (streak_reg != STREAK_LIMIT)  streak_reg <= streak_reg + 4'd1;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                        to_cnt_reg    <= '0;
`endif
                    end
                end
                ACC_IF, ACC_D: begin
                    if (bus.mem_ready) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        if (state_reg == ACC_IF) begin
                            if_rvalid_reg <= 1'b1;
                            if_rdata_reg  <= bus.mem_rdata;
                        end else begin
                            d_rvalid_reg  <= 1'b1;
                            d_rdata_reg   <= mem_we_reg ? '0 : bus.mem_rdata;
                        end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        err_reg     <= 1'b1;
                        if (state_reg == ACC_IF) begin
                            if_rvalid_reg <= 1'b1;
                            if_rdata_reg  <= DW'(32'hDEAD_BEEF);
                        end else begin
                            d_rvalid_reg  <= 1'b1;
                            d_rdata_reg   <= DW'(32'hDEAD_BEEF);
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = pick_if;
    assign bus.d_gnt     = pick_d;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rvalid  = d_rvalid_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.mem_rdata = memf(bus.mem_addr);
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    function automatic logic [199:0] all_outs();
        return 200'({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                     bus.d_rdata, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                     bus.busy, bus.err});
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        #1;
        n_cmp++; if (all_outs() !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        rst_n = 1'b1;
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
        #1;
        n_cmp++; if (bus.d_gnt !== 1'b1) begin n_bad++; $display("FAIL reset_pre_dgnt: got %b want 1", bus.d_gnt); end
        cyc();
        bus.d_req = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL reset_pre_busy: busy %b mem_req %b want 1 1", bus.busy, bus.mem_req); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (all_outs() !== '0) begin n_bad++; $display("FAIL reset_mid_outs: got %h want 0", all_outs()); end
        cyc();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_after: d_rvalid %b busy %b want 0 0", bus.d_rvalid, bus.busy); end
        end
        bus.mem_ready = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        #1;
        n_cmp++; if (bus.if_gnt !== 1'b1) begin n_bad++; $display("FAIL reset_post_ifgnt: got %b want 1", bus.if_gnt); end
        cyc();
        bus.if_req = 1'b0; bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (bus.mem_addr !== 32'h40) begin n_bad++; $display("FAIL reset_post_addr: got %h want 00000040", bus.mem_addr); end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== memf(32'h40)) begin n_bad++; $display("FAIL reset_post_rdata: rvalid %b rdata %h want 1 %h", bus.if_rvalid, bus.if_rdata, memf(32'h40)); end
        $display("test_reset done");
    endtask

    task automatic test_fetch();
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        n_cmp++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_bad++; $display("FAIL fetch_gnt: if_gnt %b d_gnt %b want 1 0", bus.if_gnt, bus.d_gnt); end
        cyc();
        bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0050_0093;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100 || bus.if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_access: req %b we %b addr %h rvalid %b want 1 0 100 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.if_rvalid); end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0050_0093 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL fetch_return: rvalid %b rdata %h req %b busy %b want 1 00500093 0 0", bus.if_rvalid, bus.if_rdata, bus.mem_req, bus.busy); end
        cyc();
        #1;
        n_cmp++; if (bus.if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse: rvalid %b want 0", bus.if_rvalid); end
        $display("test_fetch done");
    endtask

    task automatic test_simultaneous();
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin n_bad++; $display("FAIL sim_first: d_gnt %b if_gnt %b want 1 0", bus.d_gnt, bus.if_gnt); end
        cyc();
        bus.d_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_addr !== 32'h2000 || bus.if_gnt !== 1'b0) begin n_bad++; $display("FAIL sim_daddr: addr %h if_gnt %b want 2000 0", bus.mem_addr, bus.if_gnt); end
        cyc();
        #1;
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== memf(32'h2000) || bus.if_gnt !== 1'b1) begin n_bad++; $display("FAIL sim_dret: d_rvalid %b d_rdata %h if_gnt %b want 1 %h 1", bus.d_rvalid, bus.d_rdata, bus.if_gnt, memf(32'h2000)); end
        cyc();
        bus.if_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_addr !== 32'h180) begin n_bad++; $display("FAIL sim_ifaddr: addr %h want 180", bus.mem_addr); end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== memf(32'h180) || bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL sim_ifret: if_rvalid %b if_rdata %h d_rvalid %b want 1 %h 0", bus.if_rvalid, bus.if_rdata, bus.d_rvalid, memf(32'h180)); end
        $display("test_simultaneous done");
    endtask

    task automatic test_store();
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (bus.d_gnt !== 1'b1) begin n_bad++; $display("FAIL store_gnt: got %b want 1", bus.d_gnt); end
        for (int i = 0; i < 6; i++) begin
            cyc();
            bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
            bus.mem_rdata = 32'hFFFF_FFFF;
            bus.mem_ready = (i == 5);
            #1;
            n_cmp++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h2004 || bus.mem_wdata !== 32'hCAFE_F00D || bus.d_rvalid !== 1'b0) begin
                n_bad++; $display("FAIL store_hold[%0d]: req %b we %b addr %h wdata %h rvalid %b want 1 1 2004 cafef00d 0", i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_rvalid);
            end
        end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL store_done: rvalid %b rdata %h want 1 0", bus.d_rvalid, bus.d_rdata); end
        $display("test_store done");
    endtask

    task automatic test_streak();
        int seq[$];
        for (int c = 0; c < 80 && seq.size() < 10; c++) begin
            cyc();
            bus.if_req = 1'b1; bus.if_addr = $urandom();
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = $urandom();
            bus.mem_ready = 1'b1;
            #1;
            if (bus.if_gnt === 1'b1) seq.push_back(1);
            else if (bus.d_gnt === 1'b1) seq.push_back(0);
        end
        n_cmp++; if (seq.size() != 10) begin n_bad++; $display("FAIL streak_count: got %0d grants want 10", seq.size()); end
        for (int n = 0; n < seq.size(); n++) begin
            n_cmp++;
            if (seq[n] != (((n % (MAXS + 1)) == MAXS) ? 1 : 0)) begin
                n_bad++; $display("FAIL streak_seq[%0d]: got %s want %s", n, seq[n] ? "IF" : "D", ((n % (MAXS + 1)) == MAXS) ? "IF" : "D");
            end
        end
        idle_inputs();
        bus.mem_ready = 1'b1;
        repeat (3) cyc();
        bus.mem_ready = 1'b0;
        cyc();
        $display("test_streak done: %0d grants", seq.size());
    endtask

    task automatic test_random();
        logic          if_pend = 1'b0, d_pend = 1'b0, d_we_m = 1'b0;
        logic [31:0]   if_a = '0, d_a = '0, d_wd = '0;
        int            owner = 0, rv_owner = 0, streak = 0, wcnt = 0;
        logic          acc_we = 1'b0;
        logic [31:0]   acc_addr = '0, acc_wdata = '0, rv_data = '0;
        logic          exp_if_g, exp_d_g;
        int            grants = 0;
        for (int c = 0; c < 500; c++) begin
            cyc();
            if (!if_pend) begin
                if ($urandom_range(0, 2) == 0) begin if_pend = 1'b1; if_a = $urandom(); end
            end else if ($urandom_range(0, 15) == 0) if_pend = 1'b0;
            if (!d_pend) begin
                if ($urandom_range(0, 2) == 0) begin d_pend = 1'b1; d_a = $urandom(); d_we_m = $urandom_range(0, 1) == 1; d_wd = $urandom(); end
            end else if ($urandom_range(0, 15) == 0) d_pend = 1'b0;
            bus.if_req = if_pend; bus.if_addr = if_a;
            bus.d_req = d_pend; bus.d_we = d_we_m; bus.d_addr = d_a; bus.d_wdata = d_wd;
            bus.mem_ready = (owner != 0) ? (wcnt >= 3 || $urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            exp_if_g = 1'b0; exp_d_g = 1'b0;
            if (owner == 0) begin
                if (if_pend && d_pend) begin
                    if (streak == MAXS) exp_if_g = 1'b1; else exp_d_g = 1'b1;
                end else begin
                    exp_if_g = if_pend; exp_d_g = d_pend;
                end
            end
            n_cmp++; if (bus.if_gnt !== exp_if_g || bus.d_gnt !== exp_d_g) begin n_bad++; $display("FAIL rnd_gnt c%0d: if_gnt %b d_gnt %b want %b %b", c, bus.if_gnt, bus.d_gnt, exp_if_g, exp_d_g); end
            n_cmp++; if (bus.busy !== (owner != 0) || bus.mem_req !== (owner != 0) || bus.err !== 1'b0) begin n_bad++; $display("FAIL rnd_busy c%0d: busy %b mem_req %b err %b want %b %b 0", c, bus.busy, bus.mem_req, bus.err, owner != 0, owner != 0); end
            if (owner != 0) begin
                n_cmp++;
                if (bus.mem_we !== acc_we || bus.mem_addr !== acc_addr || bus.mem_wdata !== acc_wdata) begin
                    n_bad++; $display("FAIL rnd_mem c%0d: we %b addr %h wdata %h want %b %h %h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, acc_we, acc_addr, acc_wdata);
                end
            end
            n_cmp++; if (bus.if_rvalid !== (rv_owner == 1) || bus.d_rvalid !== (rv_owner == 2)) begin n_bad++; $display("FAIL rnd_rvalid c%0d: if %b d %b want %b %b", c, bus.if_rvalid, bus.d_rvalid, rv_owner == 1, rv_owner == 2); end
            if (rv_owner == 1) begin
                n_cmp++; if (bus.if_rdata !== rv_data) begin n_bad++; $display("FAIL rnd_ifdata c%0d: got %h want %h", c, bus.if_rdata, rv_data); end
            end else if (rv_owner == 2) begin
                n_cmp++; if (bus.d_rdata !== rv_data) begin n_bad++; $display("FAIL rnd_ddata c%0d: got %h want %h", c, bus.d_rdata, rv_data); end
            end
            rv_owner = 0;
            if (owner != 0) begin
                wcnt++;
                if (bus.mem_ready) begin
                    rv_owner = owner;
                    rv_data  = acc_we ? 32'h0 : memf(acc_addr);
                    owner    = 0;
                end
            end else if (exp_if_g) begin
                owner = 1; acc_we = 1'b0; acc_addr = if_a; acc_wdata = '0;
                streak = 0; if_pend = 1'b0; wcnt = 0; grants++;
            end else if (exp_d_g) begin
                owner = 2; acc_we = d_we_m; acc_addr = d_a; acc_wdata = d_wd;
                streak = if_pend ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                d_pend = 1'b0; wcnt = 0; grants++;
            end
        end
        idle_inputs();
        bus.mem_ready = 1'b1;
        repeat (3) cyc();
        bus.mem_ready = 1'b0;
        cyc();
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_drain: busy %b want 0", bus.busy); end
        $display("test_random done: %0d grants", grants);
    endtask

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h200; bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.if_gnt !== 1'b1) begin n_bad++; $display("FAIL to_gnt: got %b want 1", bus.if_gnt); end
        for (int k = 1; k <= TO; k++) begin
            cyc();
            bus.if_req = 1'b0;
            #1;
            n_cmp++; if (bus.err !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL to_wait[%0d]: err %b rvalid %b busy %b want 0 0 1", k, bus.err, bus.if_rvalid, bus.busy); end
        end
        cyc();
        #1;
        n_cmp++; if (bus.err !== 1'b1 || bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEAD_BEEF || bus.busy !== 1'b0) begin n_bad++; $display("FAIL to_abort: err %b rvalid %b rdata %h busy %b want 1 1 deadbeef 0", bus.err, bus.if_rvalid, bus.if_rdata, bus.busy); end
        cyc();
        #1;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL to_pulse: err %b want 0", bus.err); end
        $display("test_timeout done");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_streak();
        test_random();
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between instruction fetch (IF) and load/store data access (D).
- Prepares the core for a unified instruction/data memory.
- Sits between the fetch/LSU requesters and the memory macro.
- Sequences each access through a small FSM, latches the request and returns read data with a valid pulse. Starvation of fetch is bounded by a streak counter.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_D_STREAK, 4, maximum consecutive D grants while IF is pending before IF is forced to win (1..15)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid or store done
- d_rdata  out  DW  load data (stores: 0)
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DW  memory read data, valid with mem_ready
- busy  out  1  FSM not in IDLE
- err  out  1  timeout abort pulse (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state IDLE, streak=0, all outputs 0. Reset mid-access drops the access silently; no rvalid is produced.
- States: IDLE, ACC_IF, ACC_D.
- IDLE arbitration:
  - Both requesting: D wins unless streak==MAX_D_STREAK, in which case IF wins.
  - Single requester wins.
  - On a grant: the gnt pulse is combinational in that cycle; request fields are latched into mem_* registers; mem_req=1 from the next cycle; state moves to ACC_IF or ACC_D.
- Streak counter:
  - Increments on a D grant while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any IF grant, and on a D grant with if_req=0.
- ACC_x state:
  - mem_req and mem_* are held stable until mem_ready=1.
  - On mem_ready: mem_rdata is registered into x_rdata; x_rvalid pulses the next cycle; mem_req drops; state returns to IDLE.
- Throughput: minimum 3 cycles from grant to the next grant (grant, access with mem_ready, IDLE). One access is outstanding at a time.
- The losing requester simply keeps requesting; no request is lost.
- req deasserted before gnt means the request is withdrawn; it is legal and nothing is issued.
- Stores: d_rdata=0 and d_rvalid pulses on completion.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACC_IF/ACC_D and clears on entry.
  - If TIMEOUT_CYCLES elapse without mem_ready: abort the access, pulse err for 1 cycle, pulse the owner's rvalid with rdata=32'hDEAD_BEEF, return to IDLE.
- Undefined: no counter; err tied 0; the arbiter waits indefinitely.

Test Plan:
- Reset with rst_n=0 mid-ACC_D, then release → all outputs 0, state IDLE, no d_rvalid; the next if_req is granted normally.
- if_req=1, if_addr=0x100; mem_ready one cycle after mem_req with mem_rdata=0x00500093 → if_gnt pulse, mem_addr=0x100, if_rvalid pulse with if_rdata=0x00500093, 3-cycle turnaround.
- Simultaneous if_req and d_req (load to 0x2000), memory always ready → D is granted first, then IF; d_rdata and if_rdata are returned to the correct owners.
- Continuous d_req and if_req with MAX_D_STREAK=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Store d_we=1, d_addr=0x2004, d_wdata=0xCAFEF00D; mem_ready delayed 5 cycles → mem_we/mem_addr/mem_wdata stable for all 5 cycles; d_rvalid pulses with d_rdata=0.
- With MEM_PORT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready never asserted → err pulse and if_rvalid with if_rdata=0xDEADBEEF 8 cycles after access start, then IDLE.
